banked_memory: RTL and testbench
================================

Name: banked_memory

Overview:
Multi-bank simple dual-port RAM for parallel weight/activation fetch in the accelerator datapath. One write port addresses a single bank. One read port returns the same address from all banks at once, concatenated. Adds over the single-bank RAM: a read-valid pipeline, selectable read latency, selectable read-during-write behaviour, and a hardware zero-fill sweep after reset or on request.

Parameters:
DEPTH, 8, address width in bits; each bank holds 2**DEPTH words
WIDTH, 16, word width in bits
BANKS, 4, bank count, minimum 2
READ_LATENCY, 1, cycles from read_enable to read_valid; legal values 1 or 2
BYPASS, 1, 1 = same-cycle write to the read address/bank is forwarded to the read; 0 = old data returned
ZEROS, 1, 1 = run the zero-fill sweep after reset; 0 = contents undefined after power-up, ready immediately

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous request to start or restart the zero-fill sweep
write_enable  input  1  write strobe
write_bank  input  $clog2(BANKS)  target bank of the write
write_addr  input  DEPTH  write address
data_in  input  WIDTH  write data
read_enable  input  1  read request
read_addr  input  DEPTH  read address, applied to all banks
data_out  output  BANKS*WIDTH  read data; bank 0 in bits [WIDTH-1:0], bank b in [b*WIDTH +: WIDTH]
read_valid  output  1  data_out holds the result of a read issued READ_LATENCY cycles earlier
busy  output  1  zero-fill sweep in progress; all requests ignored

Behaviour:
- Reset (rst high, asynchronous):
  - data_out = 0, read_valid = 0, read pipeline flushed, sweep counter = 0.
  - State = CLEAR if ZEROS=1, else READY; busy follows state (1 or 0).
  - RAM contents are not modified by rst itself.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle, write 0 to all banks at counter, then counter += 1. At counter = 2**DEPTH-1, write 0 and go to READY. The sweep therefore takes exactly 2**DEPTH cycles after rst deassertion.
  - READY: clear=1 -> CLEAR with counter = 0.
  - clear=1 while in CLEAR restarts the counter at 0.
  - clear is honoured regardless of ZEROS.
- busy = 1 exactly when state = CLEAR (registered).
  - While busy: write_enable and read_enable are ignored and no read_valid is generated for them.
  - Reads already in the pipeline when clear is accepted still complete, with data captured at issue.
  - Requests in the first cycle with busy=0 are accepted.
- Write (READY, write_enable=1):
  - data_in is written to bank write_bank at write_addr at the clock edge.
  - write_bank >= BANKS: write ignored.
- Read (READY, read_enable=1 in cycle T):
  - The array is sampled in cycle T at read_addr.
  - data_out is updated and read_valid = 1 in cycle T+READ_LATENCY, for one cycle per request.
  - Back-to-back reads give a continuous valid stream, one result per cycle, in issue order.
  - When no result is due: read_valid = 0 and data_out holds its last value.
- Read-during-write, same cycle, same address:
  - BYPASS=1: the written bank's slice returns data_in; other banks return stored data.
  - BYPASS=0: all slices return pre-write data.
  - Writes in cycles before T are always visible.
  - With READ_LATENCY=2, a write in cycle T+1 is not reflected in the read issued at T.
- Simultaneous clear and read/write in READY: clear wins; the request is dropped.
- Reset mid-operation: pending read results are discarded (never emitted) and the sweep restarts from 0.
- No backpressure: read results must be consumed when read_valid is high.

Test Plan:
(DEPTH=4, WIDTH=8, BANKS=4 unless stated.)
- Power-up sweep: deassert rst -> busy=1 for exactly 16 cycles, then 0. Read addresses 0..15 -> data_out=0x00000000 with read_valid one cycle after each read_enable.
- Single write/readback: write bank 2, addr 5, 0xAB; read addr 5 next cycle -> data_out=0x00AB0000, read_valid=1 one cycle later, then read_valid=0 with data_out held.
- Read-during-write at addr 3, bank 0, data 0x5A, read issued in the same cycle:
  - BYPASS=1 -> data_out=0x0000005A.
  - BYPASS=0 -> 0x00000000; a re-read on the next cycle -> 0x0000005A.
- READ_LATENCY=2: banks pre-loaded; read addr 0,1,2,3 on consecutive cycles -> read_valid high for 4 cycles starting T+2, data in order. A write to addr 1 in cycle T+1 does not change the addr 0 result.
- Clear mid-sweep: assert clear when counter=7 -> busy stays high 16 further cycles. A write of 0x11 issued while busy is ignored; reading that address afterwards -> 0x00.
- rst mid-read: read at T, assert rst at T+1 (READ_LATENCY=2) -> read_valid never asserts, data_out=0, busy=1. Previously written data (ZEROS=0 build) is still readable after rst deasserts.

Source files
------------

// File: rtl/banked_memory.sv
// ---------------------------------------------------------------------------
// banked_memory
//   Multi-bank simple dual-port RAM. One write port targets a single bank;
//   one read port returns the same address from every bank, concatenated.
//   A registered read pipeline adds a read-valid strobe. The read latency is
//   1 or 2 cycles. Read-during-write forwarding is selectable. A zero-fill
//   sweep runs after reset (ZEROS=1) or whenever clear is requested.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset (RAM contents untouched)
//   clear         synchronous request to start/restart the zero-fill sweep
//   write_enable  write strobe
//   write_bank    target bank of the write (out-of-range banks are ignored)
//   write_addr    write address
//   data_in       write data
//   read_enable   read request
//   read_addr     read address, applied to all banks
//   data_out      read data, bank b in [b*WIDTH +: WIDTH]
//   read_valid    data_out holds a result issued READ_LATENCY cycles earlier
//   busy          zero-fill sweep in progress; requests are ignored
// ---------------------------------------------------------------------------
module banked_memory #(
  parameter int DEPTH        = 8,
  parameter int WIDTH        = 16,
  parameter int BANKS        = 4,
  parameter int READ_LATENCY = 1,
  parameter bit BYPASS       = 1'b1,
  parameter bit ZEROS        = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       write_enable,
  input  logic [$clog2(BANKS)-1:0]   write_bank,
  input  logic [DEPTH-1:0]           write_addr,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       read_enable,
  input  logic [DEPTH-1:0]           read_addr,
  output logic [BANKS*WIDTH-1:0]     data_out,
  output logic                       read_valid,
  output logic                       busy
);

  localparam int               BW         = $clog2(BANKS);
  localparam int               WORDS      = 2 ** DEPTH;
  // One extra bit so non-power-of-two bank counts can be range checked.
  localparam logic [BW:0]      BANK_COUNT = (BW + 1)'(BANKS);
  localparam logic [DEPTH-1:0] LAST_ADDR  = DEPTH'(WORDS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                   state_r;
  logic                     busy_r;
  logic [DEPTH-1:0]         sweep_cnt_r;
  logic [WIDTH-1:0]         mem_r [BANKS][WORDS];

  logic                     bank_ok_s;
  logic                     wr_acc_s;
  logic                     rd_acc_s;
  logic [BANKS*WIDTH-1:0]   rd_data_s;
  logic                     res_valid_s;
  logic [BANKS*WIDTH-1:0]   res_data_s;
  logic [BANKS*WIDTH-1:0]   data_out_r;
  logic                     read_valid_r;

  // Request qualification: only READY accepts, and clear beats any request.
  always_comb begin
    bank_ok_s = ({1'b0, write_bank} < BANK_COUNT);
    if ((state_r == ST_READY) && !clear) begin
      wr_acc_s = write_enable && bank_ok_s;
      rd_acc_s = read_enable;
    end else begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
    end
  end

  // Sweep FSM: CLEAR walks every address once, then hands over to READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ZEROS ? ST_CLEAR : ST_READY;
      busy_r      <= ZEROS;
      sweep_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clear) begin
            sweep_cnt_r <= '0;
          end else if (sweep_cnt_r == LAST_ADDR) begin
            state_r     <= ST_READY;
            busy_r      <= 1'b0;
            sweep_cnt_r <= '0;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + DEPTH'(1);
          end
        end
        ST_READY: begin
          if (clear) begin
            state_r     <= ST_CLEAR;
            busy_r      <= 1'b1;
            sweep_cnt_r <= '0;
          end
        end
        default: begin
          state_r     <= ST_CLEAR;
          busy_r      <= 1'b1;
          sweep_cnt_r <= '0;
        end
      endcase
    end
  end

  // RAM array: the sweep zeroes one address in every bank per cycle,
  // otherwise an accepted write updates its single target bank.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (state_r == ST_CLEAR) begin
        mem_r[b][sweep_cnt_r] <= '0;
      end else if (wr_acc_s && (write_bank == BW'(b))) begin
        mem_r[b][write_addr] <= data_in;
      end
    end
  end

  // Array sample for the read issued this cycle, with optional forwarding
  // of a same-cycle write to the same address into its own bank slice.
  always_comb begin
    rd_data_s = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (BYPASS && wr_acc_s && (write_bank == BW'(b)) && (write_addr == read_addr)) begin
        rd_data_s[b*WIDTH +: WIDTH] = data_in;
      end else begin
        rd_data_s[b*WIDTH +: WIDTH] = mem_r[b][read_addr];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                   stage_valid_r;
      logic [BANKS*WIDTH-1:0] stage_data_r;

      // Extra stage: data is captured at issue, so later writes cannot leak in.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_valid_r <= 1'b0;
          stage_data_r  <= '0;
        end else begin
          stage_valid_r <= rd_acc_s;
          if (rd_acc_s) begin
            stage_data_r <= rd_data_s;
          end
        end
      end

      assign res_valid_s = stage_valid_r;
      assign res_data_s  = stage_data_r;
    end else begin : g_lat1
      assign res_valid_s = rd_acc_s;
      assign res_data_s  = rd_data_s;
    end
  endgenerate

  // Output register: data_out holds its last result between valid strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_valid_r <= 1'b0;
      data_out_r   <= '0;
    end else begin
      read_valid_r <= res_valid_s;
      if (res_valid_s) begin
        data_out_r <= res_data_s;
      end
    end
  end

  assign data_out   = data_out_r;
  assign read_valid = read_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_banked_memory.sv
// ---------------------------------------------------------------------------
// tb_banked_memory
//   Two instances share one stimulus stream:
//     dut0: DEPTH=4 WIDTH=8 BANKS=4 READ_LATENCY=1 BYPASS=1 ZEROS=1
//     dut1: DEPTH=4 WIDTH=8 BANKS=4 READ_LATENCY=2 BYPASS=0 ZEROS=0
//   A behavioural model predicts busy/read_valid/data_out for both and is
//   compared every falling edge; directed steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_banked_memory;

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        clear = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  wbank = 2'd0;
  logic [3:0]  waddr = 4'd0;
  logic [7:0]  din   = 8'd0;
  logic        re    = 1'b0;
  logic [3:0]  raddr = 4'd0;

  logic [31:0] dout0, dout1;
  logic        rv0, rv1, bsy0, bsy1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  banked_memory #(
    .DEPTH(4), .WIDTH(8), .BANKS(4), .READ_LATENCY(1), .BYPASS(1'b1), .ZEROS(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .write_enable(we), .write_bank(wbank),
    .write_addr(waddr), .data_in(din), .read_enable(re), .read_addr(raddr),
    .data_out(dout0), .read_valid(rv0), .busy(bsy0)
  );

  banked_memory #(
    .DEPTH(4), .WIDTH(8), .BANKS(4), .READ_LATENCY(2), .BYPASS(1'b0), .ZEROS(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .write_enable(we), .write_bank(wbank),
    .write_addr(waddr), .data_in(din), .read_enable(re), .read_addr(raddr),
    .data_out(dout1), .read_valid(rv1), .busy(bsy1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp, input logic [31:0] mask);
    n_chk++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (mask %h)", nm, act, exp, mask);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int rl_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction
  function automatic bit byp_of(input int i);
    return (i == 0);
  endfunction
  function automatic bit zer_of(input int i);
    return (i == 0);
  endfunction

  logic [7:0]  m_mem [2][4][16];
  bit          m_def [2][4][16];
  bit          m_busy [2];
  int          m_pos [2];
  // results scheduled by the cycle they are due, ring of 8 cycles
  bit          s_v [2][8];
  logic [31:0] s_d [2][8];
  logic [31:0] s_m [2][8];
  logic [31:0] e_d [2];
  logic [31:0] e_m [2];
  bit          e_v [2];
  int          cyc = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = zer_of(i);
      m_pos[i]  = 0;
      e_d[i]    = 32'h0;
      e_m[i]    = ALL;
      e_v[i]    = 1'b0;
      for (int s = 0; s < 8; s++) s_v[i][s] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] d;
    logic [31:0] m;
    int          slot;
    bit          acc;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      acc = !m_busy[i] && !clear;
      if (acc && re) begin
        d = 32'h0;
        m = 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (byp_of(i) && we && (int'(wbank) == b) && (waddr == raddr)) begin
            d[b*8 +: 8] = din;
            m[b*8 +: 8] = 8'hFF;
          end else begin
            d[b*8 +: 8] = m_mem[i][b][raddr];
            m[b*8 +: 8] = m_def[i][b][raddr] ? 8'hFF : 8'h00;
          end
        end
        slot = (cyc + rl_of(i) - 1) % 8;
        s_v[i][slot] = 1'b1;
        s_d[i][slot] = d;
        s_m[i][slot] = m;
      end
      if (acc && we) begin
        m_mem[i][wbank][waddr] = din;
        m_def[i][wbank][waddr] = 1'b1;
      end
      if (m_busy[i]) begin
        for (int b = 0; b < 4; b++) begin
          m_mem[i][b][m_pos[i]] = 8'h00;
          m_def[i][b][m_pos[i]] = 1'b1;
        end
        if (clear) m_pos[i] = 0;
        else if (m_pos[i] == 15) m_busy[i] = 1'b0;
        else m_pos[i] = m_pos[i] + 1;
      end else if (clear) begin
        m_busy[i] = 1'b1;
        m_pos[i]  = 0;
      end
      slot = cyc % 8;
      if (s_v[i][slot]) begin
        e_v[i] = 1'b1;
        e_d[i] = s_d[i][slot];
        e_m[i] = s_m[i][slot];
        s_v[i][slot] = 1'b0;
      end else begin
        e_v[i] = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 16; a++) begin
          m_mem[i][b][a] = 8'h00;
          m_def[i][b][a] = 1'b0;
        end
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("i0_busy",  32'(bsy0), 32'(m_busy[0]), ALL);
      chk("i0_valid", 32'(rv0),  32'(e_v[0]),    ALL);
      chk("i0_data",  dout0,     e_d[0],         e_m[0]);
      chk("i1_busy",  32'(bsy1), 32'(m_busy[1]), ALL);
      chk("i1_valid", 32'(rv1),  32'(e_v[1]),    ALL);
      chk("i1_data",  dout1,     e_d[1],         e_m[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    clear = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
  endtask

  initial begin
    int cnt;
    idle();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // power-up sweep length on the ZEROS=1 instance
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bsy0) cnt++;
      else break;
    end
    chk("sweep_len", 32'(cnt), 32'd16, ALL);

    // read every address starting in the first non-busy cycle
    for (int a = 0; a < 16; a++) begin
      re    = 1'b1;
      raddr = 4'(a);
      tick();
    end
    idle();
    tick();

    // single write then readback
    we = 1'b1; wbank = 2'd2; waddr = 4'd5; din = 8'hAB;
    tick();
    we = 1'b0; re = 1'b1; raddr = 4'd5;
    tick();
    chk("wr_rd_data",  dout0,     32'h00AB_0000, ALL);
    chk("wr_rd_valid", 32'(rv0),  32'd1,         ALL);
    re = 1'b0;
    tick();
    chk("hold_valid",  32'(rv0),  32'd0,         ALL);
    chk("hold_data",   dout0,     32'h00AB_0000, ALL);

    // read in flight, then clear together with a dropped read/write
    re = 1'b1; raddr = 4'd5;
    tick();
    clear = 1'b1; re = 1'b1; we = 1'b1; wbank = 2'd2; waddr = 4'd5; din = 8'hEE;
    tick();
    idle();
    chk("inflight_valid", 32'(rv1),  32'd1,         ALL);
    chk("inflight_data",  dout1,     32'h00AB_0000, 32'h00FF_0000);
    chk("clear_busy1",    32'(bsy1), 32'd1,         ALL);

    // restart the sweep when the counter reaches 7
    repeat (7) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bsy0) begin
        cnt++;
        if (cnt == 10) begin
          we = 1'b1; wbank = 2'd1; waddr = 4'd0; din = 8'h11;
        end else begin
          we = 1'b0;
        end
      end else begin
        break;
      end
    end
    we = 1'b0;
    chk("clear_restart_len", 32'(cnt), 32'd16, ALL);
    re = 1'b1; raddr = 4'd0;
    tick();
    re = 1'b0;
    chk("busy_write_ignored", dout0,    32'h0, ALL);
    chk("busy_write_valid",   32'(rv0), 32'd1, ALL);

    // read-during-write at the same address
    we = 1'b1; wbank = 2'd0; waddr = 4'd3; din = 8'h5A; re = 1'b1; raddr = 4'd3;
    tick();
    chk("raw_bypass", dout0, 32'h0000_005A, ALL);
    we = 1'b0; re = 1'b1; raddr = 4'd3;
    tick();
    chk("raw_nobypass",       dout1,    32'h0, ALL);
    chk("raw_nobypass_valid", 32'(rv1), 32'd1, ALL);
    re = 1'b0;
    tick();
    chk("reread_nobypass", dout1, 32'h0000_005A, ALL);

    // preload addr 0..3, then a back-to-back read stream
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        we = 1'b1; wbank = 2'(b); waddr = 4'(a); din = 8'(a * 16 + b + 1);
        tick();
      end
    we = 1'b0;
    re = 1'b1; raddr = 4'd0;
    tick();
    raddr = 4'd1; we = 1'b1; wbank = 2'd0; waddr = 4'd0; din = 8'h77;
    tick();
    we = 1'b0;
    chk("rl2_first",       dout1,    32'h0403_0201, ALL);
    chk("rl2_first_valid", 32'(rv1), 32'd1,         ALL);
    raddr = 4'd2;
    tick();
    chk("rl2_second", dout1, 32'h1413_1211, ALL);
    raddr = 4'd3;
    tick();
    re = 1'b0;
    repeat (2) tick();

    // reset while a latency-2 read is in flight
    re = 1'b1; raddr = 4'd1;
    tick();
    re  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid1", 32'(rv1),  32'd0, ALL);
    chk("rst_data1",  dout1,     32'h0, ALL);
    chk("rst_busy0",  32'(bsy0), 32'd1, ALL);
    tick();
    rst = 1'b0;
    re = 1'b1; raddr = 4'd1;
    tick();
    re = 1'b0;
    tick();
    chk("after_rst_data1",  dout1,    32'h1413_1211, ALL);
    chk("after_rst_valid1", 32'(rv1), 32'd1,         ALL);
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
